// File: rtl/mem_req_arbiter_if.sv
// Shared address/MESI types and the request/response/memory bundle between
// the cache controllers, the arbiter and MainMemory.
package mem_req_arbiter_pkg;
   typedef struct packed {
      logic [3:0] Page_reference;
      logic [7:0] Address_code;
   } Taddress;

   typedef logic [1:0] Tmesi_state;
endpackage

interface mem_req_arbiter_if
   import mem_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
) ();
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_we;
   Taddress                   req_addr [NUM_REQ];
   logic [NUM_REQ-1:0][63:0]  req_wdata;
   Tmesi_state                req_mesi [NUM_REQ];

   logic [NUM_REQ-1:0]        resp_valid;
   logic                      resp_err;
   logic [63:0]               resp_rdata;
   Tmesi_state                resp_mesi;

   Taddress                   mem_addr;
   logic [63:0]               mem_wdata;
   logic                      mem_we;
   Tmesi_state                mem_mesi_in;
   logic [63:0]               mem_rdata;
   Tmesi_state                mem_mesi_out;

   // Arbiter side.
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_mesi,
      input  mem_rdata, mem_mesi_out,
      output resp_valid, resp_err, resp_rdata, resp_mesi,
      output mem_addr, mem_wdata, mem_we, mem_mesi_in
   );

   // Requesters plus memory side.
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_mesi,
      output mem_rdata, mem_mesi_out,
      input  resp_valid, resp_err, resp_rdata, resp_mesi,
      input  mem_addr, mem_wdata, mem_we, mem_mesi_in
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter/sequencer in front of MainMemory: IDLE -> ISSUE -> RESP,
// one transaction in flight, out-of-range pages answered with an error.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int NUM_PAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   mem_req_arbiter_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] last_gnt;
   logic [IW-1:0] idx;
   logic          lat_we;
   logic          rd_pass;

   logic          found;
   logic [IW-1:0] win;
   logic [IW-1:0] cand_idx;
   int            cand;
   logic          win_err;

   // Search starts just after the previous winner, so a loser is served next.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_gnt) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IW'(cand);
         if (!found && bus.req_valid[cand_idx]) begin
            found = 1'b1;
            win   = cand_idx;
         end
      end
   end

   assign win_err = !(int'(bus.req_addr[win].Page_reference) < NUM_PAGES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         last_gnt        <= IW'(NUM_REQ - 1);
         idx             <= '0;
         lat_we          <= 1'b0;
         rd_pass         <= 1'b0;
         bus.resp_valid  <= '0;
         bus.resp_err    <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.mem_we      <= 1'b0;
         bus.mem_mesi_in <= '0;
      end else begin
         bus.mem_we     <= 1'b0;
         bus.resp_valid <= '0;
         bus.resp_err   <= 1'b0;
         rd_pass        <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  idx      <= win;
                  last_gnt <= win;
                  lat_we   <= bus.req_we[win];
                  if (win_err) begin
                     state          <= RESP;
                     bus.resp_valid <= NUM_REQ'(1) << win;
                     bus.resp_err   <= 1'b1;
                  end else begin
                     state           <= ISSUE;
                     bus.mem_addr    <= bus.req_addr[win];
                     bus.mem_wdata   <= bus.req_wdata[win];
                     bus.mem_mesi_in <= bus.req_mesi[win];
                     bus.mem_we      <= bus.req_we[win];
                  end
               end
            end
            ISSUE: begin
               state          <= RESP;
               bus.resp_valid <= NUM_REQ'(1) << idx;
               rd_pass        <= !lat_we;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Memory registers its read on the edge that enters RESP, so read data is
   // gated through from that register rather than re-registered here.
   assign bus.resp_rdata = rd_pass ? bus.mem_rdata    : '0;
   assign bus.resp_mesi  = rd_pass ? bus.mem_mesi_out : '0;

endmodule
